// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for AXI-Stream packet arbiters.
// Holds the arbiter state encoding and the rotating first-one search.
package axis_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int unsigned MAX_SRC = 8;

  // Returns the first set index of req searching upward from
  // (last+1) mod n with wrap; returns n when nothing is set.
  function automatic int unsigned rr_first(
    input logic [7:0]  req,
    input logic [2:0]  last,
    input int unsigned n
  );
    int unsigned sel;
    int unsigned idx;
    sel = n;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      idx = (32'(last) + k) % n;
      if (k <= n && sel == n && req[idx[2:0]]) begin
        sel = idx;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Finds the next requester after last_grant, wrapping around.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last_grant,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);
  import axis_arb_pkg::*;

  int unsigned sel;

  // rotating first-one over the request vector
  always_comb begin
    sel     = rr_first(8'(req), 3'(last_grant), N);
    gnt_any = (sel != N);
    gnt_idx = SW'(sel);
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-atomic round-robin AXI-Stream arbiter.
// Grant held from first beat to tlast; one registered output stage.
module axis_pkt_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  localparam int SRC_W    = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [NUM_SRC-1:0]        src_mask,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  output logic [NUM_SRC-1:0]        s_tready,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tlast,
  output logic [SRC_W-1:0]          m_tid,
  output logic                      busy,
  output logic                      pkt_done,
  output logic                      err_overlong
);
  import axis_arb_pkg::*;

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [SRC_W-1:0] LAST_RST =
    SRC_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_ERR =
    CNT_W'(MAX_BEATS - 1);

  arb_state_t state, state_nxt;

  logic [SRC_W-1:0]   grant, grant_nxt;
  logic [SRC_W-1:0]   last_grant;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;
  logic [NUM_SRC-1:0] req;
  logic [CNT_W-1:0]   beat_cnt;
  logic               out_ready;
  logic               accept;
  logic               acc_last;
  logic               set_err;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               sel_last;

  assign req       = s_tvalid & src_mask;
  assign out_ready = ~m_tvalid | m_tready;
  assign busy      = (state == ARB_LOCKED);
  assign accept    = busy & sel_valid & out_ready;
  assign acc_last  = accept & sel_last;
  assign set_err   = accept & ~sel_last &
                     (beat_cnt == CNT_ERR);

  rr_pick #(
    .N  (NUM_SRC),
    .SW (SRC_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .gnt_idx    (pick_idx),
    .gnt_any    (pick_any)
  );

  // select the granted source's beat
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == SRC_W'(i)) begin
        sel_data  = s_tdata[i*DATA_W +: DATA_W];
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
      end
    end
  end

  // next state, grant decision and source ready
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    s_tready  = '0;
    unique case (state)
      ARB_IDLE: begin
        if (enable && pick_any) begin
          state_nxt = ARB_LOCKED;
          grant_nxt = pick_idx;
        end
      end
      ARB_LOCKED: begin
        s_tready[grant] = out_ready;
        if (acc_last) begin
          state_nxt = ARB_IDLE;
        end
      end
    endcase
  end

  // state and current grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      grant <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // round-robin pointer; clear restarts at source 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= LAST_RST;
    end else if (clear) begin
      last_grant <= LAST_RST;
    end else if (acc_last) begin
      last_grant <= grant;
    end
  end

  // saturating beat counter for the open packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (acc_last) begin
      beat_cnt <= '0;
    end else if (clear && !busy) begin
      beat_cnt <= '0;
    end else if (accept && beat_cnt != CNT_MAX) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // sticky overlong flag; clear wins over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overlong <= 1'b0;
    end else if (clear) begin
      err_overlong <= 1'b0;
    end else if (set_err) begin
      err_overlong <= 1'b1;
    end
  end

  // end-of-packet pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= acc_last;
    end
  end

  // output register, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= sel_data;
      m_tlast  <= sel_last;
      m_tid    <= grant;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule
